// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART byte transmitter among N_REQ sources.
// Grants a requester, strobes tx_start, follows tx_busy to completion, then re-arbitrates.
module uart_tx_arb #(
    parameter int N_REQ  = 4,
    parameter int DW     = 8,
    parameter int TO_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DW-1:0]      req_data,
    output logic [N_REQ-1:0]         ack,
    output logic [DW-1:0]            tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic                     err
);

    localparam int          IW = $clog2(N_REQ);
    localparam int          CW = $clog2(TO_CYC);
    localparam int unsigned NR = N_REQ;

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     ptr, ptr_nxt;
    logic [IW-1:0]     win, gnt_inc, gnt_nxt;
    logic              win_vld;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [N_REQ-1:0]  ack_nxt;
    logic [DW-1:0]     tx_data_nxt;
    logic              tx_start_nxt, err_nxt;

    // Scan upward from ptr with explicit modulo-N_REQ wrap, so non-power-of-two counts work.
    always_comb begin
        int unsigned   idx;
        logic [IW-1:0] cand;
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NR) idx = idx - NR;
            cand = IW'(idx);
            if (!win_vld && req[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    assign gnt_inc = (gnt_id == IW'(NR - 1)) ? '0 : gnt_id + IW'(1);

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        cnt_nxt      = cnt;
        ack_nxt      = '0;
        tx_start_nxt = 1'b0;
        err_nxt      = 1'b0;
        gnt_nxt      = gnt_id;
        tx_data_nxt  = tx_data;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    gnt_nxt      = win;
                    tx_data_nxt  = req_data[win*DW +: DW];
                    ack_nxt[win] = 1'b1;
                    state_nxt    = START;
                end
            end
            START: begin
                tx_start_nxt = 1'b1;
                cnt_nxt      = '0;
                state_nxt    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // tx_busy is tested first so a rise coincident with the timeout wins.
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == CW'(TO_CYC - 1)) begin
                    err_nxt   = 1'b1;
                    ptr_nxt   = gnt_inc;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    ptr_nxt   = gnt_inc;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            ack      <= '0;
            tx_start <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            tx_data  <= '0;
            gnt_id   <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
            ack      <= ack_nxt;
            tx_start <= tx_start_nxt;
            err      <= err_nxt;
            busy     <= (state_nxt != IDLE);
            tx_data  <= tx_data_nxt;
            gnt_id   <= gnt_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed scoreboard bench for uart_tx_arb: grants queued at request time, checked at tx_start.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   ack;
    logic [W-1:0]   tx_data;
    logic           tx_start;
    logic           tx_busy;
    logic [1:0]     gnt_id;
    logic           busy;
    logic           err;

    always #5 clk = ~clk;

    uart_tx_arb #(.N_REQ(N), .DW(W), .TO_CYC(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .err      (err)
    );

    typedef struct {
        int         id;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   tb_ptr     = 0;
    int   rr_exp[5]  = '{0, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            int j = (tb_ptr + i) % N;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_tx_start"}, 32'(tx_start), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_tx_data"}, 32'(tx_data), 0);
        chk({tag, "_gnt_id"}, 32'(gnt_id), 0);
    endtask

    // One transfer: dly idle cycles before tx_busy rises, len cycles high; to_mode leaves tx_busy low.
    task automatic xfer(input logic [N-1:0] r, input int dly, input int len, input bit to_mode);
        int   e;
        int   n;
        exp_t p;
        exp_t it;
        e      = pick(r);
        p.id   = e;
        p.data = req_data[e*W +: W];
        sb.push_back(p);
        req = r;
        cyc();
        chk("ack", 32'(ack), 32'(1 << e));
        chk("busy_after_ack", 32'(busy), 1);
        req = '0;
        cyc();
        chk("tx_start", 32'(tx_start), 1);
        chk("ack_one_cycle", 32'(ack), 0);
        chk("sb_depth", 32'(sb.size()), 1);
        it = sb.pop_front();
        chk("gnt_id", 32'(gnt_id), 32'(it.id));
        chk("tx_data", 32'(tx_data), 32'(it.data));
        if (to_mode) begin
            n = 0;
            for (int k = 1; k <= 20; k++) begin
                cyc();
                if (err === 1'b1) begin
                    n = k;
                    break;
                end
            end
            chk("err_latency", 32'(n), TO);
            chk("busy_after_timeout", 32'(busy), 0);
            cyc();
            chk("err_one_cycle", 32'(err), 0);
        end else begin
            for (int k = 0; k < dly; k++) begin
                cyc();
                chk("no_err_wait", 32'(err), 0);
                chk("tx_start_once", 32'(tx_start), 0);
            end
            tx_busy = 1'b1;
            for (int k = 0; k < len; k++) begin
                cyc();
                chk("busy_high", 32'(busy), 1);
                chk("no_err_busy", 32'(err), 0);
            end
            tx_busy = 1'b0;
            cyc();
            chk("busy_low", 32'(busy), 0);
            chk("gnt_hold", 32'(gnt_id), 32'(it.id));
            chk("tx_data_hold", 32'(tx_data), 32'(it.data));
        end
        tb_ptr = (e + 1) % N;
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        tx_busy  = 1'b0;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        repeat (2) cyc();
        chk_reset("rst");
        rst = 1'b0;

        repeat (3) begin
            cyc();
            chk("idle_ack", 32'(ack), 0);
            chk("idle_busy", 32'(busy), 0);
        end

        for (int k = 0; k < 5; k++) begin
            xfer(4'b1111, 0, 4, 1'b0);
            chk("rr_order", 32'(gnt_id), 32'(rr_exp[k]));
        end

        req_data[23:16] = 8'hA5;
        xfer(4'b0100, 0, 20, 1'b0);
        chk("single_gnt", 32'(gnt_id), 2);
        chk("single_data", 32'(tx_data), 32'h A5);

        xfer(4'b0101, 0, 3, 1'b0);
        chk("wrap_gnt0", 32'(gnt_id), 0);
        xfer(4'b0101, 0, 3, 1'b0);
        chk("wrap_gnt2", 32'(gnt_id), 2);

        xfer(4'b1111, 0, 0, 1'b1);
        chk("timeout_gnt", 32'(gnt_id), 3);
        xfer(4'b1111, 0, 3, 1'b0);
        chk("after_timeout_gnt", 32'(gnt_id), 0);

        xfer(4'b0010, TO - 1, 5, 1'b0);
        chk("tie_gnt", 32'(gnt_id), 1);

        // Abort in WAIT_DONE with the DUT pointer at 2; a reset must bring it back to 0.
        req = 4'b0001;
        cyc();
        chk("mid_ack", 32'(ack), 1);
        req = '0;
        cyc();
        chk("mid_tx_start", 32'(tx_start), 1);
        tx_busy = 1'b1;
        repeat (3) cyc();
        chk("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        cyc();
        chk_reset("midrst");
        rst     = 1'b0;
        tx_busy = 1'b0;
        repeat (3) begin
            cyc();
            chk("post_rst_ack", 32'(ack), 0);
            chk("post_rst_err", 32'(err), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end
        tb_ptr = 0;
        xfer(4'b1001, 0, 3, 1'b0);
        chk("post_rst_gnt", 32'(gnt_id), 0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
